tc_bank_sched: RTL and testbench

TC_BANK_SCHED -- requirements
Module: tc_bank_sched

---
 rtl/tc_bank_sched.sv | 183 ++++++++++++++++++
 tb/tb_tc_bank_sched.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tc_bank_sched.sv
// Double-buffered point-bank loader: fills two banks from a stream, swaps on core request, tracks line/frame position.
// Optional macro TC_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter output.
module tc_bank_sched #(
    parameter int PPL_W  = 10,
    parameter int LPF_W  = 8,
    parameter int DATA_W = 17
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [PPL_W-1:0]  points_per_line_i,
    input  logic [LPF_W-1:0]  lines_per_frame_i,
    input  logic              s_valid_i,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              s_ready_o,
    input  logic              update_mem_i,
    input  logic              line_completed_i,
    output logic [PPL_W:0]    waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              we_o,
    output logic              memory_selector_o,
    output logic              mem_updated_o,
    output logic              underrun_o,
    output logic              frame_done_o,
`ifdef TC_UNDERRUN_CNT_EN
    output logic [15:0]       underrun_cnt_o,
`endif
    output logic [LPF_W-1:0]  line_idx_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              act_q, act_d;
    logic              tgt_q, tgt_d;
    logic [1:0]        full_q, full_d;
    logic [PPL_W-1:0]  idx_q, idx_d;
    logic              pend_q, pend_d;
    logic [PPL_W-1:0]  ppl_m1_q, ppl_m1_d;
    logic [LPF_W-1:0]  lpf_m1_q, lpf_m1_d;
    logic [LPF_W-1:0]  line_q, line_d;
    logic              we_q, we_d;
    logic [PPL_W:0]    waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              upd_q, upd_d;
    logic              unr_q, unr_d;
    logic              fdone_q, fdone_d;

    logic clr, fire, last, pend_c, swap;

    assign clr       = rst_i | ~enable_i;
    assign s_ready_o = (state_q == ST_LOAD) & ~clr;
    assign fire      = s_valid_i & s_ready_o;
    assign last      = fire & (idx_q == ppl_m1_q);
    assign pend_c    = pend_q | update_mem_i;

    always_comb begin
        state_d  = state_q;
        act_d    = act_q;
        tgt_d    = tgt_q;
        full_d   = full_q;
        idx_d    = idx_q;
        pend_d   = pend_q;
        ppl_m1_d = ppl_m1_q;
        lpf_m1_d = lpf_m1_q;
        line_d   = line_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        upd_d    = 1'b0;
        unr_d    = 1'b0;
        fdone_d  = 1'b0;
        swap     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d  = ST_LOAD;
                tgt_d    = act_q;
                // a zero count is treated as one, stored as count-1
                ppl_m1_d = (points_per_line_i == '0) ? '0 : points_per_line_i - 1'b1;
                lpf_m1_d = (lines_per_frame_i == '0) ? '0 : lines_per_frame_i - 1'b1;
            end
            ST_LOAD: begin
                if (fire) begin
                    we_d    = 1'b1;
                    waddr_d = {tgt_q, idx_q};
                    wdata_d = s_data_i;
                    idx_d   = last ? '0 : idx_q + 1'b1;
                end
                if (last) begin
                    full_d[tgt_q] = 1'b1;
                    if (tgt_q == act_q) tgt_d = ~act_q;
                    else                state_d = ST_HOLD;
                end
            end
            default: ;
        endcase

        if (state_q != ST_IDLE) begin
            // full_d already includes a bank completed by this cycle's final beat
            swap = pend_c & full_d[~act_q];
            if (swap) begin
                full_d[act_q] = 1'b0;
                act_d         = ~act_q;
                pend_d        = 1'b0;
                upd_d         = 1'b1;
                if (state_d == ST_HOLD) begin
                    state_d = ST_LOAD;
                    tgt_d   = act_q;
                end
            end else begin
                pend_d = pend_c;
                unr_d  = update_mem_i & ~pend_q;
            end

            if (line_completed_i) begin
                if (line_q == lpf_m1_q) begin
                    line_d  = '0;
                    fdone_d = 1'b1;
                end else begin
                    line_d = line_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            act_q    <= 1'b0;
            tgt_q    <= 1'b0;
            full_q   <= '0;
            idx_q    <= '0;
            pend_q   <= 1'b0;
            ppl_m1_q <= '0;
            lpf_m1_q <= '0;
            line_q   <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            upd_q    <= 1'b0;
            unr_q    <= 1'b0;
            fdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            act_q    <= act_d;
            tgt_q    <= tgt_d;
            full_q   <= full_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            ppl_m1_q <= ppl_m1_d;
            lpf_m1_q <= lpf_m1_d;
            line_q   <= line_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            upd_q    <= upd_d;
            unr_q    <= unr_d;
            fdone_q  <= fdone_d;
        end
    end

`ifdef TC_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q;
    always_ff @(posedge clk_i) begin
        if (clr)                              ucnt_q <= '0;
        else if (unr_q && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
    end
    assign underrun_cnt_o = ucnt_q;
`endif

    assign waddr_o           = waddr_q;
    assign wdata_o           = wdata_q;
    assign we_o              = we_q;
    assign memory_selector_o = act_q;
    assign mem_updated_o     = upd_q;
    assign underrun_o        = unr_q;
    assign frame_done_o      = fdone_q;
    assign line_idx_o        = line_q;

endmodule

// File: tb/tb_tc_bank_sched.sv
// Directed bench for tc_bank_sched: write-port scoreboard plus point checks of swap, underrun, frame and abort behaviour.
module tb_tc_bank_sched;
    localparam int PPL_W  = 4;
    localparam int LPF_W  = 8;
    localparam int DATA_W = 17;

    logic              clk = 1'b0;
    logic              rst, en, s_valid, s_ready, upd_req, lc;
    logic [PPL_W-1:0]  ppl;
    logic [LPF_W-1:0]  lpf;
    logic [DATA_W-1:0] s_data, wdata;
    logic [PPL_W:0]    waddr;
    logic              we, sel, mem_upd, unr, fdone;
    logic [LPF_W-1:0]  line_idx;

    int errors = 0;
    int checks = 0;
    logic [PPL_W+DATA_W:0] exp_q[$];

    tc_bank_sched #(.PPL_W(PPL_W), .LPF_W(LPF_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en),
        .points_per_line_i(ppl), .lines_per_frame_i(lpf),
        .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
        .update_mem_i(upd_req), .line_completed_i(lc),
        .waddr_o(waddr), .wdata_o(wdata), .we_o(we),
        .memory_selector_o(sel), .mem_updated_o(mem_upd),
        .underrun_o(unr), .frame_done_o(fdone), .line_idx_o(line_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every write seen on the port must match the oldest pending expectation
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {10'd0, waddr, wdata}, 32'hFFFF_FFFF);
            end else begin
                logic [PPL_W+DATA_W:0] e;
                e = exp_q.pop_front();
                chk("write", {10'd0, waddr, wdata}, {10'd0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DATA_W-1:0] d, input logic [PPL_W:0] a);
        s_valid = 1'b1;
        s_data  = d;
        exp_q.push_back({a, d});
        tick();
        s_valid = 1'b0;
    endtask

    task automatic line_pulse();
        lc = 1'b1;
        tick();
        lc = 1'b0;
    endtask

    initial begin
        logic [LPF_W-1:0] exp_line [6] = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd0};
        logic             exp_fd   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        int               fd_cnt;
        rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = '0;
        upd_req = 1'b0; lc = 1'b0; ppl = 4'd4; lpf = 8'd3;
        repeat (3) tick();
        chk("rst_ready", s_ready, 0);
        chk("rst_we", we, 0);
        chk("rst_outs", {sel, mem_upd, unr, fdone}, 0);
        chk("rst_addr_data", {waddr, wdata}, 0);
        chk("rst_line", line_idx, 0);

        // priming both banks
        rst = 1'b0; en = 1'b1;
        tick();
        chk("load_ready", s_ready, 1);
        for (int i = 0; i < 8; i++)
            beat(17'h10000 | (17'h31 * (i + 1)), (i < 4) ? 5'(i) : 5'(12 + i));
        chk("hold_ready", s_ready, 0);
        chk("prime_sel", sel, 0);

        // swap from HOLD
        upd_req = 1'b1;
        tick();
        upd_req = 1'b0;
        chk("swap_pulse", mem_upd, 1);
        chk("swap_sel", sel, 1);
        chk("swap_ready", s_ready, 1);
        chk("swap_no_unr", unr, 0);
        tick();
        chk("swap_pulse_end", mem_upd, 0);
        for (int i = 0; i < 4; i++) beat(17'h00A00 + 17'(i), 5'(i));
        chk("refill_hold", s_ready, 0);
        upd_req = 1'b1;
        tick();
        upd_req = 1'b0;
        chk("swap2_sel", {mem_upd, sel}, 2'b10);

        // underrun: bank 1 empty, then filled; final beat completes the swap
        upd_req = 1'b1;
        tick();
        upd_req = 1'b0;
        chk("unr_pulse", unr, 1);
        chk("unr_no_swap", mem_upd, 0);
        tick();
        chk("unr_end", unr, 0);
        upd_req = 1'b1;
        tick();
        upd_req = 1'b0;
        chk("unr_absorbed", unr, 0);
        for (int i = 0; i < 3; i++) beat(17'h1F000 + 17'(i), 5'(16 + i));
        chk("unr_wait", {mem_upd, sel}, 2'b00);
        beat(17'h0BEEF, 5'd19);
        chk("late_swap", {mem_upd, sel, s_ready}, 3'b111);
        tick();
        chk("late_swap_end", mem_upd, 0);

        // frame counting; config change after start must be ignored
        lpf = 8'd7;
        fd_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            line_pulse();
            chk("line_idx", line_idx, exp_line[i]);
            chk("frame_done", fdone, exp_fd[i]);
            if (fdone) fd_cnt++;
            tick();
            chk("frame_done_end", fdone, 0);
        end
        chk("frame_count", fd_cnt, 2);

        // abort mid-line and restart
        en = 1'b0; ppl = 4'd4; lpf = 8'd3;
        tick();
        en = 1'b1;
        tick();
        line_pulse();
        chk("abort_pre_line", line_idx, 1);
        beat(17'h12345, 5'd0);
        beat(17'h06789, 5'd1);
        en = 1'b0;
        tick();
        chk("abort_ready", s_ready, 0);
        chk("abort_we", we, 0);
        chk("abort_addr_data", {waddr, wdata}, 0);
        chk("abort_outs", {sel, mem_upd, unr, fdone}, 0);
        chk("abort_line", line_idx, 0);
        en = 1'b1;
        tick();
        beat(17'h1AAAA, 5'd0);

        // zero configuration
        en = 1'b0; ppl = '0; lpf = '0;
        tick();
        en = 1'b1;
        tick();
        beat(17'h00111, 5'd0);
        beat(17'h00222, 5'd16);
        chk("zero_hold", s_ready, 0);
        for (int i = 0; i < 2; i++) begin
            line_pulse();
            chk("zero_frame", {line_idx, fdone}, 9'd1);
        end

        tick();
        tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
